decodificador_buzzer: RTL



---
 rtl/decodificador_buzzer_if.sv | 19 +
 rtl/decodificador_buzzer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decodificador_buzzer_if.sv
// Note-code input and buzzer/status outputs between the game core and the buzzer decoder.
interface decodificador_buzzer_if;
  logic [2:0] note_code;
  logic       buzzer;
  logic       tocando;
  logic [2:0] nota_atual;
  logic       expirou;
  logic [1:0] db_estado;

  modport master (
    output note_code,
    input  buzzer, tocando, nota_atual, expirou, db_estado
  );

  modport slave (
    input  note_code,
    output buzzer, tocando, nota_atual, expirou, db_estado
  );
endinterface

// File: rtl/decodificador_buzzer.sv
// Synchronises and debounces the 3-bit note code, then drives a 50 % duty square wave
// on the piezo, cutting the tone off after MAX_CYCLES of a single note.
module decodificador_buzzer #(
  parameter int unsigned DIV_SHIFT     = 0,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MAX_CYCLES    = 100_000_000
) (
  input logic                  clock,
  input logic                  reset,
  decodificador_buzzer_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    TOCANDO  = 2'd1,
    EXPIRADO = 2'd2
  } state_t;

  localparam logic [3:0]  STABLE   = 4'(STABLE_CYCLES);
  localparam logic [26:0] DUR_LAST = 27'(MAX_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  s1, s2;
  logic [2:0]  cand;
  logic [3:0]  cnt;
  logic        valid;
  logic        retune;
  logic [2:0]  nota;
  logic        buzzer_q;
  logic [16:0] phase;
  logic [16:0] half;
  logic [26:0] dur;

  function automatic logic [16:0] half_of(input logic [2:0] code);
    logic [16:0] base;
    logic [16:0] shifted;
    case (code)
      3'd1:    base = 17'd95556;
      3'd2:    base = 17'd85131;
      3'd3:    base = 17'd75843;
      3'd4:    base = 17'd71586;
      3'd5:    base = 17'd63776;
      3'd6:    base = 17'd56818;
      3'd7:    base = 17'd50619;
      default: base = '0;
    endcase
    shifted = base >> DIV_SHIFT;
    if (shifted == '0) shifted = 17'd1;
    return shifted;
  endfunction

  assign half = half_of(nota);

  // Two-flop synchroniser followed by the stability filter; cnt saturates at STABLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      s1 <= bus.note_code;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 4'd1;
      end else if (cnt != STABLE) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign valid = (cnt == STABLE);

  always_ff @(posedge clock) begin
    if (reset) state <= OCIOSO;
    else       state <= state_next;
  end

  // Retune is checked ahead of expiry so a new note on the expiry edge keeps playing.
  always_comb begin
    state_next = state;
    retune     = 1'b0;
    case (state)
      OCIOSO: begin
        if (valid && cand != '0) begin
          state_next = TOCANDO;
          retune     = 1'b1;
        end
      end
      TOCANDO: begin
        if (valid && cand == '0) begin
          state_next = OCIOSO;
        end else if (valid && cand != nota) begin
          retune = 1'b1;
        end else if (dur == DUR_LAST) begin
          state_next = EXPIRADO;
        end
      end
      EXPIRADO: begin
        if (valid && cand == '0) begin
          state_next = OCIOSO;
        end else if (valid && cand != nota) begin
          state_next = TOCANDO;
          retune     = 1'b1;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nota     <= '0;
      buzzer_q <= 1'b0;
      phase    <= '0;
      dur      <= '0;
    end else if (retune) begin
      nota     <= cand;
      buzzer_q <= 1'b1;
      phase    <= '0;
      dur      <= '0;
    end else begin
      case (state_next)
        TOCANDO: begin
          dur <= dur + 27'd1;
          if (phase == half - 17'd1) begin
            buzzer_q <= ~buzzer_q;
            phase    <= '0;
          end else begin
            phase <= phase + 17'd1;
          end
        end
        EXPIRADO: begin
          buzzer_q <= 1'b0;
          phase    <= '0;
          dur      <= '0;
        end
        default: begin
          nota     <= '0;
          buzzer_q <= 1'b0;
          phase    <= '0;
          dur      <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.tocando    = (state == TOCANDO);
    bus.expirou    = (state == EXPIRADO);
    bus.db_estado  = state;
    bus.buzzer     = buzzer_q;
    bus.nota_atual = nota;
  end

endmodule
